// File: rtl/barrel_shifter_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shifter_arbiter_if
// Description : Requester handshakes and shifter hookup for the shared
//               barrel-shifter arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface barrel_shifter_arbiter_if #(
    parameter int SWR = 26,
    parameter int EWR = 5
);
    logic           req0_i;
    logic [EWR-1:0] shamt0_i;
    logic [SWR-1:0] data0_i;
    logic           lr0_i;
    logic           bit0_i;
    logic           ack0_o;
    logic           done0_o;

    logic           req1_i;
    logic [EWR-1:0] shamt1_i;
    logic [SWR-1:0] data1_i;
    logic           lr1_i;
    logic           bit1_i;
    logic           ack1_o;
    logic           done1_o;

    logic [SWR-1:0] result_o;
    logic           busy_o;

    logic           sh_load_o;
    logic [EWR-1:0] sh_value_o;
    logic [SWR-1:0] sh_data_o;
    logic           sh_lr_o;
    logic           sh_bit_o;
    logic [SWR-1:0] sh_result_i;

    modport slave (
        input  req0_i, shamt0_i, data0_i, lr0_i, bit0_i,
        input  req1_i, shamt1_i, data1_i, lr1_i, bit1_i,
        input  sh_result_i,
        output ack0_o, done0_o, ack1_o, done1_o,
        output result_o, busy_o,
        output sh_load_o, sh_value_o, sh_data_o, sh_lr_o, sh_bit_o
    );

    modport master (
        output req0_i, shamt0_i, data0_i, lr0_i, bit0_i,
        output req1_i, shamt1_i, data1_i, lr1_i, bit1_i,
        output sh_result_i,
        input  ack0_o, done0_o, ack1_o, done1_o,
        input  result_o, busy_o,
        input  sh_load_o, sh_value_o, sh_data_o, sh_lr_o, sh_bit_o
    );
endinterface
`default_nettype wire

// File: rtl/barrel_shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shifter_arbiter
// Description : Round-robin sharing of one registered barrel shifter between
//               two requesters; every output is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shifter_arbiter #(
    parameter int SWR = 26,
    parameter int EWR = 5,
    parameter int LAT = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    barrel_shifter_arbiter_if.slave   bus
);
    localparam logic [3:0] c_CNT_INIT = 4'(LAT - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         r_state, w_state_nx;
    logic [3:0]     r_cnt, w_cnt_nx;
    logic           r_last, w_last_nx;
    logic           r_owner, w_owner_nx;
    logic           r_ack0, w_ack0_nx;
    logic           r_ack1, w_ack1_nx;
    logic           r_done0, w_done0_nx;
    logic           r_done1, w_done1_nx;
    logic [SWR-1:0] r_result, w_result_nx;
    logic           r_busy, w_busy_nx;
    logic           r_sh_load, w_sh_load_nx;
    logic [EWR-1:0] r_sh_value, w_sh_value_nx;
    logic [SWR-1:0] r_sh_data, w_sh_data_nx;
    logic           r_sh_lr, w_sh_lr_nx;
    logic           r_sh_bit, w_sh_bit_nx;
    logic           w_grant1;

    // last resets to 1 so requester 0 takes the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_sh_load  <= 1'b0;
            r_sh_value <= '0;
            r_sh_data  <= '0;
            r_sh_lr    <= 1'b0;
            r_sh_bit   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_last     <= w_last_nx;
            r_owner    <= w_owner_nx;
            r_ack0     <= w_ack0_nx;
            r_ack1     <= w_ack1_nx;
            r_done0    <= w_done0_nx;
            r_done1    <= w_done1_nx;
            r_result   <= w_result_nx;
            r_busy     <= w_busy_nx;
            r_sh_load  <= w_sh_load_nx;
            r_sh_value <= w_sh_value_nx;
            r_sh_data  <= w_sh_data_nx;
            r_sh_lr    <= w_sh_lr_nx;
            r_sh_bit   <= w_sh_bit_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_last_nx     = r_last;
        w_owner_nx    = r_owner;
        w_ack0_nx     = 1'b0;
        w_ack1_nx     = 1'b0;
        w_done0_nx    = 1'b0;
        w_done1_nx    = 1'b0;
        w_result_nx   = r_result;
        w_busy_nx     = r_busy;
        w_sh_load_nx  = r_sh_load;
        w_sh_value_nx = r_sh_value;
        w_sh_data_nx  = r_sh_data;
        w_sh_lr_nx    = r_sh_lr;
        w_sh_bit_nx   = r_sh_bit;
        w_grant1      = 1'b0;

        case (r_state)
            IDLE: begin
                w_sh_load_nx = 1'b0;
                w_busy_nx    = 1'b0;
                if (bus.req0_i || bus.req1_i) begin
                    // requester 1 wins when alone, or on a tie when 0 went last
                    w_grant1      = bus.req1_i && (!bus.req0_i || !r_last);
                    w_owner_nx    = w_grant1;
                    w_ack0_nx     = !w_grant1;
                    w_ack1_nx     = w_grant1;
                    w_sh_load_nx  = 1'b1;
                    w_busy_nx     = 1'b1;
                    w_cnt_nx      = c_CNT_INIT;
                    w_state_nx    = SHIFT;
                    w_sh_value_nx = w_grant1 ? bus.shamt1_i : bus.shamt0_i;
                    w_sh_data_nx  = w_grant1 ? bus.data1_i  : bus.data0_i;
                    w_sh_lr_nx    = w_grant1 ? bus.lr1_i    : bus.lr0_i;
                    w_sh_bit_nx   = w_grant1 ? bus.bit1_i   : bus.bit0_i;
                end
            end
            SHIFT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    w_result_nx  = bus.sh_result_i;
                    w_done0_nx   = !r_owner;
                    w_done1_nx   = r_owner;
                    w_sh_load_nx = 1'b0;
                    w_busy_nx    = 1'b0;
                    w_last_nx    = r_owner;
                    w_state_nx   = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign bus.ack0_o     = r_ack0;
    assign bus.ack1_o     = r_ack1;
    assign bus.done0_o    = r_done0;
    assign bus.done1_o    = r_done1;
    assign bus.result_o   = r_result;
    assign bus.busy_o     = r_busy;
    assign bus.sh_load_o  = r_sh_load;
    assign bus.sh_value_o = r_sh_value;
    assign bus.sh_data_o  = r_sh_data;
    assign bus.sh_lr_o    = r_sh_lr;
    assign bus.sh_bit_o   = r_sh_bit;
endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_shifter_arbiter
// Description : Directed scoreboard bench for barrel_shifter_arbiter with a
//               one-register behavioural shifter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shifter_arbiter;
    localparam int SWR = 26;
    localparam int EWR = 5;
    localparam int LAT = 2;

    typedef struct {
        logic           owner;
        logic [SWR-1:0] res;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    exp_t exp_q[$];
    logic prev_busy;

    barrel_shifter_arbiter_if #(.SWR(SWR), .EWR(EWR)) bus ();

    barrel_shifter_arbiter #(.SWR(SWR), .EWR(EWR), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SWR-1:0] shift_f(input logic [SWR-1:0] d,
                                               input logic [EWR-1:0] s,
                                               input logic lr, input logic b);
        logic [SWR-1:0] ones;
        ones = '1;
        if (lr) shift_f = (d << s) | (b ? ~(ones << s) : '0);
        else    shift_f = (d >> s) | (b ? ~(ones >> s) : '0);
    endfunction

    // Shifter stand-in: one register stage, sampled by the arbiter LAT edges after load
    always_ff @(posedge clk) begin
        if (bus.sh_load_o)
            bus.sh_result_i <= shift_f(bus.sh_data_o, bus.sh_value_o, bus.sh_lr_o, bus.sh_bit_o);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic any_out();
        any_out = bus.ack0_o | bus.ack1_o | bus.done0_o | bus.done1_o | bus.busy_o |
                  bus.sh_load_o | bus.sh_lr_o | bus.sh_bit_o | (|bus.sh_value_o) |
                  (|bus.sh_data_o) | (|bus.result_o);
    endfunction

    // Monitor: pops the scoreboard on every done and checks handshake exclusivity
    initial begin
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done0_o || bus.done1_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {30'd0, bus.done1_o, bus.done0_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", {31'd0, bus.done1_o}, {31'd0, e.owner});
                    check("done_result", {6'd0, bus.result_o}, {6'd0, e.res});
                end
            end
            if (bus.ack0_o || bus.ack1_o || bus.done0_o || bus.done1_o)
                check("handshake_exclusive",
                      {28'd0, bus.ack0_o & bus.ack1_o, bus.done0_o & bus.done1_o,
                       bus.ack0_o & bus.done0_o, bus.ack1_o & bus.done1_o}, 32'd0);
            if (bus.ack0_o || bus.ack1_o)
                check("no_ack_while_busy", {31'd0, prev_busy}, 32'd0);
            prev_busy = bus.busy_o;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Single left shift by requester 0: 0x10 << 3 = 0x80
    task automatic single_req0();
        bus.req0_i = 1'b1; bus.shamt0_i = 5'd3; bus.data0_i = 26'h0000010;
        bus.lr0_i = 1'b1; bus.bit0_i = 1'b0;
        exp_q.push_back('{owner: 1'b0, res: 26'h0000080});
        step();
        check("s1_ack0", {31'd0, bus.ack0_o}, 32'd1);
        check("s1_load_busy", {30'd0, bus.sh_load_o, bus.busy_o}, 32'd3);
        check("s1_sh_data", {6'd0, bus.sh_data_o}, 32'h0000010);
        check("s1_sh_value_lr", {26'd0, bus.sh_value_o, bus.sh_lr_o}, {26'd0, 5'd3, 1'b1});
        bus.req0_i = 1'b0;
        step();
        check("s1_load_t2", {30'd0, bus.sh_load_o, bus.ack0_o}, 32'd2);
        step();
        check("s1_done_t3", {29'd0, bus.done0_o, bus.done1_o, bus.sh_load_o}, 32'd4);
        check("s1_idle_busy", {31'd0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        int n;
        int last_cyc;
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1;
        bus.req0_i = 1'b0; bus.shamt0_i = '0; bus.data0_i = '0; bus.lr0_i = 1'b0; bus.bit0_i = 1'b0;
        bus.req1_i = 1'b0; bus.shamt1_i = '0; bus.data1_i = '0; bus.lr1_i = 1'b0; bus.bit1_i = 1'b0;
        do_reset();
        check("reset_outputs", {31'd0, any_out()}, 32'd0);

        single_req0();
        step();

        // Tie after reset: grants alternate 0,1,0,1, dones LAT+1 cycles apart
        do_reset();
        bus.shamt0_i = 5'd5; bus.data0_i = 26'h0000001; bus.lr0_i = 1'b1; bus.bit0_i = 1'b0;
        bus.shamt1_i = 5'd8; bus.data1_i = 26'h0000F00; bus.lr1_i = 1'b0; bus.bit1_i = 1'b0;
        exp_q.push_back('{owner: 1'b0, res: 26'h0000020});
        exp_q.push_back('{owner: 1'b1, res: 26'h000000F});
        exp_q.push_back('{owner: 1'b0, res: 26'h0000020});
        exp_q.push_back('{owner: 1'b1, res: 26'h000000F});
        bus.req0_i = 1'b1; bus.req1_i = 1'b1;
        n = 0; last_cyc = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            step();
            if (bus.done0_o || bus.done1_o) begin
                n++;
                if (n > 1) check("tie_done_spacing", 32'(cyc - last_cyc), 32'(LAT + 1));
                last_cyc = cyc;
                if (n == 4) begin
                    bus.req0_i = 1'b0; bus.req1_i = 1'b0;
                end
            end
        end
        check("tie_done_count", 32'(n), 32'd4);
        bus.req0_i = 1'b0; bus.req1_i = 1'b0;
        repeat (3) step();

        // Request 1 arrives mid-shift; then a right shift with one-fill
        bus.req0_i = 1'b1; bus.shamt0_i = 5'd3; bus.data0_i = 26'h0000010;
        bus.lr0_i = 1'b1; bus.bit0_i = 1'b0;
        exp_q.push_back('{owner: 1'b0, res: 26'h0000080});
        exp_q.push_back('{owner: 1'b1, res: 26'h3E00000});
        step();
        check("mid_ack0", {30'd0, bus.ack0_o, bus.ack1_o}, 32'd2);
        bus.req0_i = 1'b0;
        bus.req1_i = 1'b1; bus.shamt1_i = 5'd4; bus.data1_i = 26'h2000000;
        bus.lr1_i = 1'b0; bus.bit1_i = 1'b1;
        step();
        check("mid_t2_no_ack1", {31'd0, bus.ack1_o}, 32'd0);
        step();
        check("mid_t3_done0", {30'd0, bus.done0_o, bus.ack1_o}, 32'd2);
        step();
        check("mid_t4_ack1", {31'd0, bus.ack1_o}, 32'd1);
        bus.req1_i = 1'b0;
        step();
        step();
        check("mid_t6_done1", {31'd0, bus.done1_o}, 32'd1);
        repeat (3) step();
        check("result_hold", {6'd0, bus.result_o}, 32'h3E00000);

        // Reset mid-shift aborts with no done
        bus.req0_i = 1'b1; bus.shamt0_i = 5'd1; bus.data0_i = 26'h0000003;
        step();
        check("abort_ack0", {31'd0, bus.ack0_o}, 32'd1);
        bus.req0_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("abort_outputs_clear", {31'd0, any_out()}, 32'd0);
        rst = 1'b0;
        single_req0();
        step();

        // Operands latched at grant survive input changes during SHIFT
        bus.req0_i = 1'b1; bus.shamt0_i = 5'd2; bus.data0_i = 26'h0001234;
        bus.lr0_i = 1'b1; bus.bit0_i = 1'b1;
        exp_q.push_back('{owner: 1'b0, res: 26'h00048D3});
        step();
        check("stab_ack0", {31'd0, bus.ack0_o}, 32'd1);
        bus.req0_i = 1'b0; bus.data0_i = 26'h3FFFFFF; bus.shamt0_i = 5'd7;
        step();
        check("stab_sh_data", {6'd0, bus.sh_data_o}, 32'h0001234);
        check("stab_sh_value", {27'd0, bus.sh_value_o}, 32'd2);
        step();
        check("stab_done0", {31'd0, bus.done0_o}, 32'd1);
        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
